// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: level requests, per-requester burst
// base addresses, grant pulse and the tagged read-data return path.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int DW      = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*AW-1:0] base_addr;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rd_valid;
  logic [DW-1:0]         rd_data;
  logic                  rd_last;
  logic                  busy;

  modport master (
    output req, base_addr,
    input  gnt, rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    input  req, base_addr,
    output gnt, rd_valid, rd_data, rd_last, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one negedge-clocked sprite ROM among NUM_REQ row fetchers.
// Optional macro SPRITE_ARB_PRIO0_EN gives requester 0 absolute priority at arbitration.
//
// state   | meaning
// S_IDLE  | arbitration cycle; a winner gets gnt and beat 0 is issued at the clock edge
// S_ISSUE | issuing beats 1..BURST_LEN-1, one per cycle
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int AW        = 8,
  parameter int DW        = 4,
  parameter int BURST_LEN = 16,
  parameter int ROM_LAT   = 1
) (
  input  logic                 i_vga_clk,
  input  logic                 i_reset,
  sprite_rom_arbiter_if.slave  io_req_bus,
  output logic [AW-1:0]        o_rom_address,
  input  logic [DW-1:0]        i_rom_q
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_LEN + 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [AW-1:0]      r_addr, w_addr_nxt;
  logic [CW-1:0]      r_left, w_left_nxt;
  logic [PW-1:0]      r_id, w_id_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_issue, w_issue_last;
  logic [PW-1:0]      w_issue_id;
  logic [PW-1:0]      w_idx, w_win;
  logic               w_found;

  logic [ROM_LAT-1:0] r_pv, r_pl;
  logic [PW-1:0]      r_pid [ROM_LAT];
  logic [NUM_REQ-1:0] r_rd_valid, w_rd_valid_nxt;
  logic [DW-1:0]      r_rd_data;
  logic               r_rd_last;

  // Winner: first requesting bit scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = PW'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && io_req_bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`ifdef SPRITE_ARB_PRIO0_EN
    if (io_req_bus.req[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_addr_nxt   = r_addr;
    w_left_nxt   = r_left;
    w_id_nxt     = r_id;
    w_gnt        = '0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_issue_id   = r_id;
    case (r_state)
      S_IDLE: begin
        if (w_found && !i_reset) begin
          w_gnt[w_win] = 1'b1;
          w_addr_nxt   = io_req_bus.base_addr[w_win*AW +: AW];
          w_id_nxt     = w_win;
          w_issue      = 1'b1;
          w_issue_id   = w_win;
`ifdef SPRITE_ARB_PRIO0_EN
          if (w_win != '0)
            w_rr_ptr_nxt = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
`else
          w_rr_ptr_nxt = (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
`endif
          if (BURST_LEN == 1) begin
            w_issue_last = 1'b1;
          end else begin
            w_left_nxt  = CW'(BURST_LEN - 1);
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_addr_nxt = r_addr + 1'b1;
        w_left_nxt = r_left - 1'b1;
        w_issue    = 1'b1;
        if (r_left == CW'(1)) begin
          w_issue_last = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_addr   <= '0;
      r_left   <= '0;
      r_id     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_addr   <= w_addr_nxt;
      r_left   <= w_left_nxt;
      r_id     <= w_id_nxt;
    end
  end

  // Tag stage 0 lines up with the beat on o_rom_address; the last stage meets its rom_q.
  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_pv <= '0;
      r_pl <= '0;
      for (int i = 0; i < ROM_LAT; i++) r_pid[i] <= '0;
    end else begin
      r_pv[0]  <= w_issue;
      r_pl[0]  <= w_issue_last;
      r_pid[0] <= w_issue_id;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pl[i]  <= r_pl[i-1];
        r_pid[i] <= r_pid[i-1];
      end
    end
  end

  always_comb begin
    w_rd_valid_nxt = '0;
    if (r_pv[ROM_LAT-1]) w_rd_valid_nxt[r_pid[ROM_LAT-1]] = 1'b1;
  end

  always_ff @(posedge i_vga_clk) begin
    if (i_reset) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= i_rom_q;
      r_rd_last  <= r_pv[ROM_LAT-1] & r_pl[ROM_LAT-1];
    end
  end

  assign o_rom_address       = r_addr;
  assign io_req_bus.gnt      = w_gnt;
  assign io_req_bus.rd_valid = r_rd_valid;
  assign io_req_bus.rd_data  = r_rd_data;
  assign io_req_bus.rd_last  = r_rd_last;
  assign io_req_bus.busy     = (r_state == S_ISSUE) | (|r_pv);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a negedge-clocked ROM model (q = a[3:0]^a[7:4]).
module tb_sprite_rom_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rom_address;
  logic [3:0] rom_q = 4'h0;
  int         tests = 0;
  int         fails = 0;

  sprite_rom_arbiter_if #(.NUM_REQ(4), .AW(8), .DW(4)) bus ();

  sprite_rom_arbiter #(
    .NUM_REQ(4), .AW(8), .DW(4), .BURST_LEN(16), .ROM_LAT(1)
  ) dut (
    .i_vga_clk     (clk),
    .i_reset       (reset),
    .io_req_bus    (bus),
    .o_rom_address (rom_address),
    .i_rom_q       (rom_q)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_f(input logic [7:0] a);
    return a[3:0] ^ a[7:4];
  endfunction

  always @(negedge clk) rom_q <= rom_f(rom_address);

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_base(input int id, input logic [7:0] b);
    bus.base_addr[id*8 +: 8] = b;
  endtask

  // Called in the grant cycle; req is dropped after the grant edge.
  task automatic chk_burst(input int id, input logic [7:0] base);
    logic [7:0] a;
    logic [3:0] oh;
    oh = 4'b0001 << id;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1) bus.req = 4'b0000;
      #1;
      if (c <= 16) begin
        a = base + 8'(c - 1);
        chk("addr", rom_address, a);
        chk("busy_on", bus.busy, 1'b1);
        chk("gnt_idle", bus.gnt, 4'b0000);
      end
      if (c >= 2) begin
        a = base + 8'(c - 2);
        chk("rd_valid", bus.rd_valid, oh);
        chk("rd_data", bus.rd_data, rom_f(a));
        chk("rd_last", bus.rd_last, (c == 17));
      end
    end
    chk("busy_off", bus.busy, 1'b0);
  endtask

  initial begin
    logic [3:0] oh;
    logic [7:0] bases [4];
    int id;
    bus.req = '0;
    bus.base_addr = '0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_addr", rom_address, 8'h00);
    chk("rst_valid", bus.rd_valid, 4'b0000);
    chk("rst_data", bus.rd_data, 4'h0);
    chk("rst_last", bus.rd_last, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    tick();

    // Single burst to requester 1
    set_base(1, 8'h20);
    bus.req = 4'b0010;
    #1 chk("t1_gnt", bus.gnt, 4'b0010);
    chk_burst(1, 8'h20);

    // Address wrap modulo 256
    set_base(3, 8'hF8);
    bus.req = 4'b1000;
    #1 chk("t3_gnt", bus.gnt, 4'b1000);
    chk_burst(3, 8'hF8);

    // One-cycle request still gets a full burst
    set_base(2, 8'h90);
    bus.req = 4'b0100;
    #1 chk("t5_gnt", bus.gnt, 4'b0100);
    chk_burst(2, 8'h90);

    // Reset at beat 5 flushes everything
    set_base(0, 8'h40);
    bus.req = 4'b0001;
    #1 chk("t4_gnt", bus.gnt, 4'b0001);
    tick();
    bus.req = 4'b0000;
    repeat (5) tick();
    #1 chk("t4_beat5", rom_address, 8'h45);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t4_gnt0", bus.gnt, 4'b0000);
    chk("t4_addr0", rom_address, 8'h00);
    chk("t4_valid0", bus.rd_valid, 4'b0000);
    chk("t4_data0", bus.rd_data, 4'h0);
    chk("t4_last0", bus.rd_last, 1'b0);
    chk("t4_busy0", bus.busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_flush_valid", bus.rd_valid, 4'b0000);
      chk("t4_flush_busy", bus.busy, 1'b0);
    end

    // All requesting: grants 0,1,2,3,0 every 16 cycles
    bases[0] = 8'h00; bases[1] = 8'h30; bases[2] = 8'h50; bases[3] = 8'h70;
    for (int i = 0; i < 4; i++) set_base(i, bases[i]);
    bus.req = 4'b1111;
    #1;
    for (int b = 0; b < 5; b++) begin
      id = b % 4;
      oh = 4'b0001 << id;
      chk("t2_gnt", bus.gnt, oh);
      tick();
      if (b == 4) bus.req = 4'b0000;
      #1 chk("t2_addr", rom_address, bases[id]);
      for (int k = 0; k < 14; k++) begin
        tick();
        chk("t2_gap", bus.gnt, 4'b0000);
      end
      if (b < 4) begin
        tick();
        #1;
      end
    end
    repeat (4) tick();
    chk("t2_busy_off", bus.busy, 1'b0);

    // Requester 0 raised during requester 1's burst
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 4'b1110;
    #1 chk("t6_gnt1", bus.gnt, 4'b0010);
    repeat (5) tick();
    bus.req = 4'b1111;
    repeat (10) tick();
    #1 chk("t6_no_preempt", bus.gnt, 4'b0000);
    tick();
    #1;
`ifdef SPRITE_ARB_PRIO0_EN
    chk("t6_next_gnt", bus.gnt, 4'b0001);
`else
    chk("t6_next_gnt", bus.gnt, 4'b0100);
`endif
    bus.req = 4'b0000;
    repeat (20) tick();
    chk("t6_busy_off", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
